aes_chain_datapath: RTL and testbench

//  Chaining datapath driven by the AES mode controller's strobes (fb_load_iv, fb_update,
//  ctr_load, ctr_inc, data_valid). Owns the feedback (IV/chain) and counter registers.

---
 rtl/aes_chain_datapath.sv | 119 +++++++++++
 tb/tb_aes_chain_datapath.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/aes_chain_datapath.sv
// Purpose: block-chaining datapath (ECB/CBC/CFB/OFB/CTR) around an external AES core.
// Latency: core_in is combinational; result appears one cycle after data_valid.
// Backpressure: a single result register; a block that arrives while it is full is dropped and flagged on overrun.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   mode, decrypt       chaining mode (0 ECB,1 CBC,2 CFB,3 OFB,4 CTR) and direction
//   data_in, iv         input block and IV / initial counter block
//   aes_out             AES core output for the current block
//   fb_load_iv, fb_update, ctr_load, ctr_inc, data_valid   controller strobes
//   core_in             AES core input
//   result, result_valid, result_ready   valid/ready result port
//   overrun             sticky dropped-block flag
//   block_count         results captured since reset
module aes_chain_datapath #(
  parameter int CTR_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   mode,
  input  logic         decrypt,
  input  logic [127:0] data_in,
  input  logic [127:0] iv,
  input  logic [127:0] aes_out,
  input  logic         fb_load_iv,
  input  logic         fb_update,
  input  logic         ctr_load,
  input  logic         ctr_inc,
  input  logic         data_valid,
  output logic [127:0] core_in,
  output logic [127:0] result,
  output logic         result_valid,
  input  logic         result_ready,
  output logic         overrun,
  output logic [31:0]  block_count
);

  localparam logic [2:0] MODE_ECB = 3'd0;
  localparam logic [2:0] MODE_CBC = 3'd1;
  localparam logic [2:0] MODE_CFB = 3'd2;
  localparam logic [2:0] MODE_OFB = 3'd3;
  localparam logic [2:0] MODE_CTR = 3'd4;

  // Bits of the counter that take part in the increment; everything above is frozen.
  localparam logic [127:0] CTR_MASK = (CTR_W >= 128) ? {128{1'b1}}
                                                     : ((128'd1 << CTR_W) - 128'd1);

  logic [127:0] fb;
  logic [127:0] ctr;
  logic [127:0] fb_next;
  logic [127:0] ctr_next;
  logic [127:0] result_next;
  logic         out_full;
  logic         capture;

  always_comb begin
    core_in = data_in;
    case (mode)
      MODE_CBC:           if (!decrypt) core_in = data_in ^ fb;
      MODE_CFB, MODE_OFB: core_in = fb;
      MODE_CTR:           core_in = ctr;
      default:            core_in = data_in;
    endcase
  end

  // Uses the pre-update fb: fb_update lands in the same cycle as data_valid.
  always_comb begin
    result_next = aes_out;
    case (mode)
      MODE_CBC:                     if (decrypt) result_next = aes_out ^ fb;
      MODE_CFB, MODE_OFB, MODE_CTR: result_next = data_in ^ aes_out;
      default:                      result_next = aes_out;
    endcase
  end

  always_comb begin
    fb_next = fb;
    case (mode)
      MODE_CBC: fb_next = decrypt ? data_in : aes_out;
      MODE_CFB: fb_next = decrypt ? data_in : (data_in ^ aes_out);
      MODE_OFB: fb_next = aes_out;
      default:  fb_next = fb;
    endcase
  end

  // Carries only move upward, so masking the full-width sum gives the low field mod 2^CTR_W.
  assign ctr_next = (ctr & ~CTR_MASK) | ((ctr + 128'd1) & CTR_MASK);

  assign out_full = result_valid && !result_ready;
  assign capture  = data_valid && !out_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      fb           <= '0;
      ctr          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
      block_count  <= '0;
    end else begin
      if (fb_load_iv)     fb <= iv;
      else if (fb_update) fb <= fb_next;

      if (ctr_load)     ctr <= iv;
      else if (ctr_inc) ctr <= ctr_next;

      if (capture) begin
        result       <= result_next;
        result_valid <= 1'b1;
        block_count  <= block_count + 32'd1;
      end else if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end

      if (data_valid && out_full) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_chain_datapath.sv
module tb_aes_chain_datapath;

  logic         clk;
  logic         reset;
  logic [2:0]   mode;
  logic         decrypt;
  logic [127:0] data_in;
  logic [127:0] iv;
  logic [127:0] aes_out;
  logic         fb_load_iv;
  logic         fb_update;
  logic         ctr_load;
  logic         ctr_inc;
  logic         data_valid;
  logic [127:0] core_in;
  logic [127:0] result;
  logic         result_valid;
  logic         result_ready;
  logic         overrun;
  logic [31:0]  block_count;

  aes_chain_datapath #(.CTR_W(32)) dut (
    .clk(clk), .reset(reset), .mode(mode), .decrypt(decrypt),
    .data_in(data_in), .iv(iv), .aes_out(aes_out),
    .fb_load_iv(fb_load_iv), .fb_update(fb_update),
    .ctr_load(ctr_load), .ctr_inc(ctr_inc), .data_valid(data_valid),
    .core_in(core_in), .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .overrun(overrun), .block_count(block_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] D1   = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] I1   = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] X1   = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
  localparam logic [127:0] AA   = {16{8'hAA}};
  localparam logic [127:0] F0   = {16{8'hF0}};
  localparam logic [127:0] OF   = {16{8'h0F}};
  localparam logic [127:0] FF   = {16{8'hFF}};
  localparam logic [127:0] CB   = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] CIV  = 128'h123456789ABCDEF000000000FFFFFFFF;
  localparam logic [127:0] CWR  = 128'h123456789ABCDEF00000000000000000;
  localparam logic [127:0] I1P1 = 128'h000102030405060708090A0B0C0D0E10;

  typedef struct {
    logic [2:0]   mode;
    logic         dec;
    logic         inc;
    logic [127:0] din;
    logic [127:0] iv;
    logic [127:0] aes;
    logic [127:0] exp_core;
    logic [127:0] exp_res;
    logic [127:0] exp_fb;
    logic [127:0] exp_ctr;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes;
    fb_load_iv = 1'b0; fb_update = 1'b0; ctr_load = 1'b0; ctr_inc = 1'b0; data_valid = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1; tick; reset = 1'b0;
  endtask

  logic [127:0] fb_m;
  logic [127:0] blk_aes;
  logic [127:0] blk_din;

  initial begin
    //            mode  dec   inc   din  iv   aes  core  res      fb       ctr
    vecs[0]  = '{3'd0, 1'b0, 1'b0, D1, I1, X1, D1, X1, I1, I1};
    vecs[1]  = '{3'd1, 1'b0, 1'b0, 128'hF0, 128'h01, AA, 128'hF1, AA, AA, 128'h01};
    vecs[2]  = '{3'd1, 1'b1, 1'b0, CB, OF, F0, CB, FF, CB, OF};
    vecs[3]  = '{3'd2, 1'b0, 1'b0, D1, I1, X1, I1, D1 ^ X1, D1 ^ X1, I1};
    vecs[4]  = '{3'd2, 1'b1, 1'b0, D1, I1, X1, I1, D1 ^ X1, D1, I1};
    vecs[5]  = '{3'd3, 1'b0, 1'b0, D1, I1, X1, I1, D1 ^ X1, X1, I1};
    vecs[6]  = '{3'd3, 1'b1, 1'b0, D1, I1, X1, I1, D1 ^ X1, X1, I1};
    vecs[7]  = '{3'd4, 1'b0, 1'b1, D1, CIV, X1, CIV, D1 ^ X1, CIV, CWR};
    vecs[8]  = '{3'd5, 1'b0, 1'b0, D1, I1, X1, D1, X1, I1, I1};
    vecs[9]  = '{3'd7, 1'b1, 1'b0, D1, I1, X1, D1, X1, I1, I1};
    vecs[10] = '{3'd4, 1'b1, 1'b1, D1, I1, X1, I1, D1 ^ X1, I1, I1P1};

    reset = 1'b1; mode = 3'd0; decrypt = 1'b0; data_in = '0; iv = '0; aes_out = '0;
    result_ready = 1'b0;
    clear_strobes();
    tick; tick;
    reset = 1'b0;

    // Reset state
    chk("rst result", result, '0);
    chk("rst valid", 128'(result_valid), 128'd0);
    chk("rst overrun", 128'(overrun), 128'd0);
    chk("rst count", 128'(block_count), 128'd0);
    mode = 3'd3; #1 chk("rst fb", core_in, '0);
    mode = 3'd4; #1 chk("rst ctr", core_in, '0);

    // Per-mode vectors; fb and ctr are observed by switching mode to OFB / CTR afterwards
    for (int i = 0; i < NV; i++) begin
      mode = vecs[i].mode; decrypt = vecs[i].dec; data_in = vecs[i].din;
      iv = vecs[i].iv; aes_out = vecs[i].aes; result_ready = 1'b1;
      fb_load_iv = 1'b1; ctr_load = 1'b1;
      tick;
      clear_strobes();
      chk($sformatf("v%0d core_in", i), core_in, vecs[i].exp_core);
      data_valid = 1'b1; fb_update = 1'b1; ctr_inc = vecs[i].inc;
      tick;
      clear_strobes();
      chk($sformatf("v%0d result", i), result, vecs[i].exp_res);
      chk($sformatf("v%0d valid", i), 128'(result_valid), 128'd1);
      chk($sformatf("v%0d count", i), 128'(block_count), 128'(i + 1));
      mode = 3'd3; #1 chk($sformatf("v%0d fb", i), core_in, vecs[i].exp_fb);
      mode = 3'd4; #1 chk($sformatf("v%0d ctr", i), core_in, vecs[i].exp_ctr);
    end

    // Backpressure: second block dropped while output is full
    do_reset();
    mode = 3'd0; result_ready = 1'b0;
    aes_out = X1; data_valid = 1'b1; tick;
    aes_out = AA; tick;
    data_valid = 1'b0;
    chk("bp result", result, X1);
    chk("bp valid", 128'(result_valid), 128'd1);
    chk("bp overrun", 128'(overrun), 128'd1);
    chk("bp count", 128'(block_count), 128'd1);
    result_ready = 1'b1; tick;
    chk("bp drain valid", 128'(result_valid), 128'd0);
    chk("bp overrun sticky", 128'(overrun), 128'd1);

    // Consume and capture in the same cycle
    do_reset();
    mode = 3'd0; result_ready = 1'b0;
    aes_out = X1; data_valid = 1'b1; tick;
    result_ready = 1'b1; aes_out = AA; tick;
    data_valid = 1'b0;
    chk("sim result", result, AA);
    chk("sim valid", 128'(result_valid), 128'd1);
    chk("sim overrun", 128'(overrun), 128'd0);
    chk("sim count", 128'(block_count), 128'd2);
    mode = 3'd3; iv = I1; aes_out = X1; fb_load_iv = 1'b1; fb_update = 1'b1; tick;
    clear_strobes();
    chk("load beats update", core_in, I1);

    // Reset mid-block dominates concurrent strobes
    mode = 3'd0; iv = I1; aes_out = X1; result_ready = 1'b0;
    fb_load_iv = 1'b1; ctr_load = 1'b1; data_valid = 1'b1; tick;
    clear_strobes();
    reset = 1'b1; data_valid = 1'b1; fb_update = 1'b1; ctr_inc = 1'b1; mode = 3'd3;
    tick;
    reset = 1'b0; clear_strobes();
    chk("mid rst result", result, '0);
    chk("mid rst valid", 128'(result_valid), 128'd0);
    chk("mid rst overrun", 128'(overrun), 128'd0);
    chk("mid rst count", 128'(block_count), 128'd0);
    mode = 3'd3; #1 chk("mid rst fb", core_in, '0);
    mode = 3'd4; #1 chk("mid rst ctr", core_in, '0);

    // OFB over three blocks against a small keystream model
    mode = 3'd3; decrypt = 1'b0; iv = I1; result_ready = 1'b1;
    fb_load_iv = 1'b1; tick; clear_strobes();
    fb_m = I1;
    for (int b = 0; b < 3; b++) begin
      blk_aes = X1 ^ 128'(b * 32'h01010101);
      blk_din = D1 + 128'(b);
      aes_out = blk_aes; data_in = blk_din;
      #1 chk($sformatf("ofb%0d core_in", b), core_in, fb_m);
      data_valid = 1'b1; fb_update = 1'b1; tick; clear_strobes();
      chk($sformatf("ofb%0d result", b), result, blk_din ^ blk_aes);
      fb_m = blk_aes;
    end
    chk("ofb final fb", core_in, fb_m);
    chk("ofb count", 128'(block_count), 128'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
